// File: rtl/regfile_mport.sv
// Multi-read, dual-write register file: per-port replicated banks, a live-value
// table choosing the newest bank per entry, and valid bits for single-cycle clear.
module regfile_mport #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 64,
  parameter int unsigned      ADDR_W    = 6,
  parameter int unsigned      NUM_RD    = 4,
  parameter int unsigned      BYPASS    = 1,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_clear,
  input  logic                     i_stall,
  input  logic                     i_wen_a,
  input  logic [ADDR_W-1:0]        i_wr_addr_a,
  input  logic [WIDTH-1:0]         i_wr_data_a,
  input  logic                     i_wen_b,
  input  logic [ADDR_W-1:0]        i_wr_addr_b,
  input  logic [WIDTH-1:0]         i_wr_data_b,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  o_rd_data
);

  localparam int unsigned CMP_W = ADDR_W + 1;

  logic [WIDTH-1:0]        bank_a [NUM_RD][DEPTH];
  logic [WIDTH-1:0]        bank_b [NUM_RD][DEPTH];
  logic [DEPTH-1:0]        valid;
  logic [DEPTH-1:0]        lvt;
  logic [DEPTH-1:0]        valid_nxt_c;
  logic [DEPTH-1:0]        lvt_nxt_c;
  logic                    wr_a_c;
  logic                    wr_b_c;
  logic [ADDR_W-1:0]       rd_addr_c [NUM_RD];
  logic [WIDTH-1:0]        rd_next_c [NUM_RD];
  logic [NUM_RD*WIDTH-1:0] rd_q;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < CMP_W'(DEPTH);
  endfunction

  assign wr_a_c = i_wen_a && in_range(i_wr_addr_a);
  assign wr_b_c = i_wen_b && in_range(i_wr_addr_b);

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_addr
    assign rd_addr_c[g] = i_rd_addr[g*ADDR_W +: ADDR_W];
  end

  // Each read lane owns a private copy of both banks, so every copy takes every write.
  always_ff @(posedge i_clk) begin
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      if (wr_a_c) bank_a[k][i_wr_addr_a] <= i_wr_data_a;
      if (wr_b_c) bank_b[k][i_wr_addr_b] <= i_wr_data_b;
    end
  end

  // Clear drops all valid bits first; same-edge writes then re-validate their entry.
  always_comb begin
    valid_nxt_c = i_clear ? '0 : valid;
    lvt_nxt_c   = lvt;
    if (wr_a_c) begin
      valid_nxt_c[i_wr_addr_a] = 1'b1;
      lvt_nxt_c[i_wr_addr_a]   = 1'b0;
    end
    if (wr_b_c) begin
      valid_nxt_c[i_wr_addr_b] = 1'b1;
      lvt_nxt_c[i_wr_addr_b]   = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      valid <= '0;
      lvt   <= '0;
    end else begin
      valid <= valid_nxt_c;
      lvt   <= lvt_nxt_c;
    end
  end

  // Port B has priority over port A on bypass, matching the LVT collision rule.
  always_comb begin
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      rd_next_c[k] = CLEAR_VAL;
      if (in_range(rd_addr_c[k])) begin
        if (BYPASS != 0 && i_wen_b && i_wr_addr_b == rd_addr_c[k])
          rd_next_c[k] = i_wr_data_b;
        else if (BYPASS != 0 && i_wen_a && i_wr_addr_a == rd_addr_c[k])
          rd_next_c[k] = i_wr_data_a;
        else if (valid[rd_addr_c[k]])
          rd_next_c[k] = lvt[rd_addr_c[k]] ? bank_b[k][rd_addr_c[k]]
                                           : bank_a[k][rd_addr_c[k]];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_q <= {NUM_RD{CLEAR_VAL}};
    end else if (!i_stall) begin
      for (int unsigned k = 0; k < NUM_RD; k++)
        rd_q[k*WIDTH +: WIDTH] <= rd_next_c[k];
    end
  end

  assign o_rd_data = rd_q;

endmodule

// File: doc/regfile_mport.md
Name: regfile_mport

Overview:
Parametrised multi-read, dual-write register file for the core's register bank. Runs on a single clock; no 2x clock or phase toggling. Built from replicated banks: one bank per write port, with NUM_RD copies of each. A live-value table (LVT) selects, per entry, which bank holds the most recent write. Per-entry valid bits give an effectively resettable and single-cycle-clearable array, with optional write-to-read bypass.

Parameters:
WIDTH, 32, data width per entry
DEPTH, 64, number of entries (2..2**ADDR_W)
ADDR_W, 6, address width
NUM_RD, 4, number of read ports (1..8)
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = read returns pre-write value
CLEAR_VAL, 0, value returned for never-written, cleared or out-of-range entries

Ports:
i_clk  in  1  clock, all state on rising edge
i_reset_n  in  1  asynchronous, active-low reset
i_clear  in  1  invalidate all entries at this edge
i_stall  in  1  hold read outputs
i_wen_a  in  1  write enable, port A
i_wr_addr_a  in  ADDR_W  write address, port A
i_wr_data_a  in  WIDTH  write data, port A
i_wen_b  in  1  write enable, port B
i_wr_addr_b  in  ADDR_W  write address, port B
i_wr_data_b  in  WIDTH  write data, port B
i_rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
o_rd_data  out  NUM_RD*WIDTH  packed registered read data; port k occupies bits [k*WIDTH +: WIDTH]

Behaviour:
- Reset (i_reset_n low, async): valid[] = 0, lvt[] = 0, every o_rd_data lane = CLEAR_VAL. RAM contents are not reset and are never observable until rewritten.
- Reset asserted mid-operation: effective immediately. After release, every entry reads CLEAR_VAL until written.
- Write, port A (i_wen_a && addr_a < DEPTH): bankA copies[addr] <= data_a; lvt[addr] <= 0; valid[addr] <= 1.
- Write, port B: same, using bankB; lvt[addr] <= 1.
- Both ports write the same address in one cycle: port B wins (lvt = 1). Port A's bank write is harmless.
- Write address >= DEPTH: write ignored; no state change.
- Read latency is 1 cycle. At edge N with !i_stall, lane k <= f(i_rd_addr[k]) evaluated on pre-edge state.
- Read function f(addr):
  - addr >= DEPTH: CLEAR_VAL.
  - else if BYPASS and i_wen_b && wr_addr_b == addr: i_wr_data_b.
  - else if BYPASS and i_wen_a && wr_addr_a == addr: i_wr_data_a.
  - else if !valid[addr]: CLEAR_VAL.
  - else: lvt[addr] ? bankB[k][addr] : bankA[k][addr].
- BYPASS = 0: same-cycle writes are not visible; the new value is visible from the next read edge.
- i_clear at edge N: valid[] <= 0 for all entries, then writes at edge N apply, so written entries end valid with the new data.
- Reads sampled at edge N of a clear cycle see the pre-clear state (bypass rules still apply). Reads from edge N+1 onward return CLEAR_VAL for uncleared-and-unwritten entries.
- i_stall = 1: o_rd_data holds its value. Writes and clear still take effect. The first edge after stall deasserts samples current addresses and state.
- Multiple read ports on the same address are independent and return identical data.
- The read path uses no combinational path from address to output; o_rd_data is flop-driven.

Test Plan:
- Post-reset: release i_reset_n; read addrs 0,5,63,10 -> o_rd_data all 0 one cycle later.
- Dual write + readback: A writes 3=0xAAAA0001, B writes 7=0xBBBB0002 at edge 1; rd addr 3,7,3,0 at edge 2 -> edge 2 outputs 0xAAAA0001, 0xBBBB0002, 0xAAAA0001, 0.
- Collision: A and B both write addr 9 (0x11, 0x22) -> later read 9 = 0x22. A alone then writes 9 = 0x33 -> read 9 = 0x33, confirming the LVT switched back to bank A.
- Bypass: with BYPASS = 1, write 4 = 0xDEAD while reading 4 in the same cycle -> 0xDEAD next cycle. With BYPASS = 0, the same stimulus returns the old value, then 0xDEAD on the next read.
- Clear: fill entries 0..63 with index values. Assert i_clear while port A writes 2 = 0x55 -> that cycle's reads return old data. The next read of 1 returns 0, of 2 returns 0x55.
- Stall / async reset: hold i_stall 3 cycles while writing addr 1 -> output frozen, then shows the new value after release. Pulse i_reset_n low between edges -> outputs become 0 immediately and all entries read 0.
